dallanma_ongorucu_gshare: RTL and testbench

Parametrised next-generation branch predictor for the fetch stage (Getir 1). It combines a tagged, typed BTB, an untagged gshare pattern table and a circular return-address stack (RAS). It keeps a speculative global history, which is repaired from execute (Yürüt) on mispredict. Prediction is combinational from the fetch PC; all table and history updates are registered.

---
 rtl/dallanma_ongorucu_gshare_if.sv | 38 +++
 rtl/dallanma_ongorucu_gshare.sv | 141 ++++++++++++++
 tb/tb_dallanma_ongorucu_gshare.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dallanma_ongorucu_gshare_if.sv
// Fetch/execute/statistics signal bundle of the gshare branch predictor.
// master: the pipeline side, slave: the predictor.
interface dallanma_ongorucu_gshare_if #(
  parameter int unsigned PS_BIT    = 32,
  parameter int unsigned GGY_BIT   = 6,
  parameter int unsigned SAYAC_BIT = 32
);
  logic                 ps_gecerli_i;
  logic [PS_BIT-1:0]    ps_i;
  logic                 atladi_o;
  logic [PS_BIT-1:0]    ongoru_o;
  logic [GGY_BIT-1:0]   ongoru_ggy_o;

  logic                 yurut_guncelle_i;
  logic [PS_BIT-1:0]    yurut_ps_i;
  logic [1:0]           yurut_tur_i;
  logic                 yurut_atladi_i;
  logic [PS_BIT-1:0]    yurut_atlanan_adres_i;
  logic [GGY_BIT-1:0]   yurut_ggy_i;
  logic                 yurut_hatali_tahmin_i;

  logic [SAYAC_BIT-1:0] dogru_sayac_o;
  logic [SAYAC_BIT-1:0] yanlis_sayac_o;

  modport master (
    output ps_gecerli_i, ps_i,
    output yurut_guncelle_i, yurut_ps_i, yurut_tur_i, yurut_atladi_i,
           yurut_atlanan_adres_i, yurut_ggy_i, yurut_hatali_tahmin_i,
    input  atladi_o, ongoru_o, ongoru_ggy_o, dogru_sayac_o, yanlis_sayac_o
  );

  modport slave (
    input  ps_gecerli_i, ps_i,
    input  yurut_guncelle_i, yurut_ps_i, yurut_tur_i, yurut_atladi_i,
           yurut_atlanan_adres_i, yurut_ggy_i, yurut_hatali_tahmin_i,
    output atladi_o, ongoru_o, ongoru_ggy_o, dogru_sayac_o, yanlis_sayac_o
  );
endinterface

// File: rtl/dallanma_ongorucu_gshare.sv
// Branch predictor: tagged typed BTB, gshare 2-bit counters, circular RAS,
// speculative global history repaired from execute on mispredict.
module dallanma_ongorucu_gshare #(
    parameter int unsigned PS_BIT       = 32,
    parameter int unsigned BTB_SATIR    = 32,
    parameter int unsigned BHT_SATIR    = 64,
    parameter int unsigned GGY_BIT      = 6,
    parameter int unsigned RAS_DERINLIK = 8,
    parameter int unsigned SAYAC_BIT    = 32
) (
    input logic clk_i,
    input logic rstn_i,
    dallanma_ongorucu_gshare_if.slave bus
);
    localparam int unsigned BTB_IDX = $clog2(BTB_SATIR);
    localparam int unsigned BHT_IDX = $clog2(BHT_SATIR);
    localparam int unsigned RAS_IDX = (RAS_DERINLIK > 1) ? $clog2(RAS_DERINLIK) : 1;
    localparam int unsigned TAG_BIT = PS_BIT - BTB_IDX - 2;

    typedef enum logic [1:0] {
        TUR_KOSUL = 2'd0,
        TUR_ATLA  = 2'd1,
        TUR_CAGRI = 2'd2,
        TUR_DONUS = 2'd3
    } tur_t;

    logic                 btb_gecerli [BTB_SATIR];
    logic [TAG_BIT-1:0]   btb_etiket  [BTB_SATIR];
    tur_t                 btb_tur     [BTB_SATIR];
    logic [PS_BIT-1:0]    btb_hedef   [BTB_SATIR];
    logic [1:0]           bht         [BHT_SATIR];
    logic [PS_BIT-1:0]    ras         [RAS_DERINLIK];
    logic [RAS_IDX-1:0]   ras_ptr;
    logic [RAS_IDX:0]     ras_sayi;
    logic [GGY_BIT-1:0]   ggy;
    logic [SAYAC_BIT-1:0] dogru;
    logic [SAYAC_BIT-1:0] yanlis;

    logic [BTB_IDX-1:0]   f_btb_idx;
    logic [TAG_BIT-1:0]   f_etiket;
    logic [BHT_IDX-1:0]   f_bht_idx;
    tur_t                 f_tur;
    logic [1:0]           f_sayac;
    logic                 isabet;
    logic                 ras_bos;
    logic [PS_BIT-1:0]    ras_ust;
    logic                 atladi;
    logic [PS_BIT-1:0]    ongoru;

    logic [BTB_IDX-1:0]   y_btb_idx;
    logic [TAG_BIT-1:0]   y_etiket;
    logic [BHT_IDX-1:0]   y_bht_idx;
    tur_t                 y_tur;
    logic                 hatali;

    // Whole-word shifts with truncating casts keep every PC bit referenced.
    always_comb begin
        f_btb_idx = BTB_IDX'(bus.ps_i >> 2);
        f_etiket  = TAG_BIT'(bus.ps_i >> (BTB_IDX + 2));
        f_bht_idx = BHT_IDX'(bus.ps_i >> 2) ^ BHT_IDX'(ggy);
        f_tur     = btb_tur[f_btb_idx];
        f_sayac   = bht[f_bht_idx];
        isabet    = bus.ps_gecerli_i && btb_gecerli[f_btb_idx] &&
                    (btb_etiket[f_btb_idx] == f_etiket);
        ras_bos   = (ras_sayi == '0);
        ras_ust   = ras[ras_ptr - RAS_IDX'(1)];
        atladi    = isabet && ((f_tur != TUR_KOSUL) || f_sayac[1]);
        ongoru    = btb_hedef[f_btb_idx];
        if (isabet && (f_tur == TUR_DONUS) && !ras_bos) ongoru = ras_ust;

        y_btb_idx = BTB_IDX'(bus.yurut_ps_i >> 2);
        y_etiket  = TAG_BIT'(bus.yurut_ps_i >> (BTB_IDX + 2));
        y_bht_idx = BHT_IDX'(bus.yurut_ps_i >> 2) ^ BHT_IDX'(bus.yurut_ggy_i);
        y_tur     = tur_t'(bus.yurut_tur_i);
        hatali    = bus.yurut_guncelle_i && bus.yurut_hatali_tahmin_i;
    end

    assign bus.atladi_o       = atladi;
    assign bus.ongoru_o       = ongoru;
    assign bus.ongoru_ggy_o   = ggy;
    assign bus.dogru_sayac_o  = dogru;
    assign bus.yanlis_sayac_o = yanlis;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < BTB_SATIR; i++) btb_gecerli[i] <= 1'b0;
            for (int unsigned i = 0; i < BHT_SATIR; i++) bht[i] <= 2'b01;
        end else if (bus.yurut_guncelle_i) begin
            if (bus.yurut_atladi_i || (y_tur != TUR_KOSUL)) btb_gecerli[y_btb_idx] <= 1'b1;
            if (y_tur == TUR_KOSUL) begin
                if (bus.yurut_atladi_i && (bht[y_bht_idx] != 2'b11))
                    bht[y_bht_idx] <= bht[y_bht_idx] + 2'b01;
                else if (!bus.yurut_atladi_i && (bht[y_bht_idx] != 2'b00))
                    bht[y_bht_idx] <= bht[y_bht_idx] - 2'b01;
            end
        end
    end

    // Payload fields are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (bus.yurut_guncelle_i && (bus.yurut_atladi_i || (y_tur != TUR_KOSUL))) begin
            btb_etiket[y_btb_idx] <= y_etiket;
            btb_tur[y_btb_idx]    <= y_tur;
            btb_hedef[y_btb_idx]  <= bus.yurut_atlanan_adres_i;
        end
        if (!hatali && isabet && (f_tur == TUR_CAGRI))
            ras[ras_ptr] <= bus.ps_i + PS_BIT'(4);
    end

    // Mispredict repair takes priority over the speculative shift/push/pop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ggy      <= '0;
            ras_ptr  <= '0;
            ras_sayi <= '0;
            dogru    <= '0;
            yanlis   <= '0;
        end else begin
            if (bus.yurut_guncelle_i) begin
                if (bus.yurut_hatali_tahmin_i) yanlis <= yanlis + SAYAC_BIT'(1);
                else                           dogru  <= dogru + SAYAC_BIT'(1);
            end
            if (hatali) begin
                if (y_tur == TUR_KOSUL) ggy <= {bus.yurut_ggy_i[GGY_BIT-2:0], bus.yurut_atladi_i};
                else                    ggy <= bus.yurut_ggy_i;
                ras_ptr  <= '0;
                ras_sayi <= '0;
            end else if (isabet) begin
                if (f_tur == TUR_KOSUL) ggy <= {ggy[GGY_BIT-2:0], f_sayac[1]};
                if (f_tur == TUR_CAGRI) begin
                    ras_ptr <= ras_ptr + RAS_IDX'(1);
                    if (ras_sayi != (RAS_IDX+1)'(RAS_DERINLIK)) ras_sayi <= ras_sayi + (RAS_IDX+1)'(1);
                end
                if ((f_tur == TUR_DONUS) && !ras_bos) begin
                    ras_ptr  <= ras_ptr - RAS_IDX'(1);
                    ras_sayi <= ras_sayi - (RAS_IDX+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_dallanma_ongorucu_gshare.sv
// Directed self-checking bench for dallanma_ongorucu_gshare with
// hand-computed expectations.
module tb_dallanma_ongorucu_gshare;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    dallanma_ongorucu_gshare_if #(.PS_BIT(32), .GGY_BIT(6), .SAYAC_BIT(32)) bus ();

    dallanma_ongorucu_gshare #(
        .PS_BIT(32), .BTB_SATIR(32), .BHT_SATIR(64),
        .GGY_BIT(6), .RAS_DERINLIK(8), .SAYAC_BIT(32)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ps_gecerli_i          = 1'b0;
        bus.ps_i                  = '0;
        bus.yurut_guncelle_i      = 1'b0;
        bus.yurut_ps_i            = '0;
        bus.yurut_tur_i           = 2'd0;
        bus.yurut_atladi_i        = 1'b0;
        bus.yurut_atlanan_adres_i = '0;
        bus.yurut_ggy_i           = '0;
        bus.yurut_hatali_tahmin_i = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.ps_gecerli_i = 1'b1;
        bus.ps_i         = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [1:0] tur, input logic atl,
                       input logic [31:0] hedef, input logic [5:0] g, input logic hat);
        bus.yurut_guncelle_i      = 1'b1;
        bus.yurut_ps_i            = pc;
        bus.yurut_tur_i           = tur;
        bus.yurut_atladi_i        = atl;
        bus.yurut_atlanan_adres_i = hedef;
        bus.yurut_ggy_i           = g;
        bus.yurut_hatali_tahmin_i = hat;
    endtask

    initial begin
        idle();
        #12 rstn = 1'b1;

        // Reset state
        @(negedge clk); idle(); fetch(32'h100); #1;
        chk("rst_atladi", 64'(bus.atladi_o), 64'd0);
        chk("rst_ggy", 64'(bus.ongoru_ggy_o), 64'd0);
        chk("rst_dogru", 64'(bus.dogru_sayac_o), 64'd0);
        chk("rst_yanlis", 64'(bus.yanlis_sayac_o), 64'd0);

        // Conditional trained twice: counter 01 -> 10 -> 11
        @(negedge clk); idle(); upd(32'h100, 2'd0, 1'b1, 32'h200, 6'd0, 1'b0);
        @(negedge clk); idle(); upd(32'h100, 2'd0, 1'b1, 32'h200, 6'd0, 1'b0);
        @(negedge clk); idle(); #1;
        chk("dogru_2", 64'(bus.dogru_sayac_o), 64'd2);
        fetch(32'h100); #1;
        chk("kosul_atladi", 64'(bus.atladi_o), 64'd1);
        chk("kosul_hedef", 64'(bus.ongoru_o), 64'h200);
        chk("kosul_ggy_once", 64'(bus.ongoru_ggy_o), 64'd0);
        @(negedge clk); idle(); #1;
        chk("kosul_ggy_sonra", 64'(bus.ongoru_ggy_o), 64'd1);

        // Call at 0x300, return at 0x810
        upd(32'h300, 2'd2, 1'b1, 32'h800, 6'd0, 1'b0);
        @(negedge clk); idle(); upd(32'h810, 2'd3, 1'b1, 32'h900, 6'd0, 1'b0);
        @(negedge clk); idle(); fetch(32'h300); #1;
        chk("cagri_atladi", 64'(bus.atladi_o), 64'd1);
        chk("cagri_hedef", 64'(bus.ongoru_o), 64'h800);
        @(negedge clk); idle(); fetch(32'h810); #1;
        chk("donus_atladi", 64'(bus.atladi_o), 64'd1);
        chk("donus_ras", 64'(bus.ongoru_o), 64'h304);
        @(negedge clk); idle(); fetch(32'h810); #1;
        chk("donus_bos_ras", 64'(bus.ongoru_o), 64'h900);

        // RAS overflow: 9 calls into 8 entries, oldest lost
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); idle(); upd(32'h1000 + 32'(k) * 32'h10, 2'd2, 1'b1, 32'h5000, 6'd0, 1'b0);
            @(negedge clk); idle(); fetch(32'h1000 + 32'(k) * 32'h10); #1;
            chk("tasma_cagri", 64'(bus.atladi_o), 64'd1);
        end
        @(negedge clk); idle(); upd(32'h2000, 2'd3, 1'b1, 32'h7000, 6'd0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); idle(); fetch(32'h2000); #1;
            chk("tasma_donus", 64'(bus.ongoru_o), 64'h1084 - 64'(j) * 64'h10);
        end
        @(negedge clk); idle(); fetch(32'h2000); #1;
        chk("tasma_bos_hedef", 64'(bus.ongoru_o), 64'h7000);
        chk("tasma_bos_atladi", 64'(bus.atladi_o), 64'd1);
        @(negedge clk); idle(); #1;
        chk("dogru_14", 64'(bus.dogru_sayac_o), 64'd14);
        chk("ggy_1", 64'(bus.ongoru_ggy_o), 64'd1);

        // Mispredict repair with a same-cycle conditional hit and pending RAS entry
        upd(32'h104, 2'd0, 1'b1, 32'h240, 6'd0, 1'b0);
        @(negedge clk); idle(); fetch(32'h1010); #1;
        chk("itme_hedef", 64'(bus.ongoru_o), 64'h5000);
        @(negedge clk); idle(); fetch(32'h104); upd(32'h500, 2'd0, 1'b0, 32'h0, 6'h2A, 1'b1); #1;
        chk("es_atladi", 64'(bus.atladi_o), 64'd1);
        chk("es_hedef", 64'(bus.ongoru_o), 64'h240);
        chk("es_ggy", 64'(bus.ongoru_ggy_o), 64'd1);
        @(negedge clk); idle(); #1;
        chk("onarim_ggy", 64'(bus.ongoru_ggy_o), 64'h14);
        chk("yanlis_1", 64'(bus.yanlis_sayac_o), 64'd1);
        chk("dogru_15", 64'(bus.dogru_sayac_o), 64'd15);
        fetch(32'h2000); #1;
        chk("ras_bosaltildi", 64'(bus.ongoru_o), 64'h7000);

        // Not-taken conditional at 0x400 must not touch the BTB
        @(negedge clk); idle(); upd(32'h400, 2'd0, 1'b0, 32'h444, 6'd0, 1'b0);
        @(negedge clk); idle(); fetch(32'h400); #1;
        chk("atlanmaz_iska", 64'(bus.atladi_o), 64'd0);
        fetch(32'h2000); #1;
        chk("btb_korundu_atladi", 64'(bus.atladi_o), 64'd1);
        chk("btb_korundu_hedef", 64'(bus.ongoru_o), 64'h7000);
        chk("dogru_16", 64'(bus.dogru_sayac_o), 64'd16);

        // Asynchronous reset mid-run
        @(negedge clk); idle(); #2 rstn = 1'b0; #1;
        chk("arst_dogru", 64'(bus.dogru_sayac_o), 64'd0);
        chk("arst_yanlis", 64'(bus.yanlis_sayac_o), 64'd0);
        chk("arst_ggy", 64'(bus.ongoru_ggy_o), 64'd0);
        fetch(32'h2000); #1;
        chk("arst_btb", 64'(bus.atladi_o), 64'd0);
        @(negedge clk); idle(); rstn = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
